udp_pingpong_writer: RTL and testbench

- Receives UDP payload as a 32-bit word stream from the MAC/UDP receive path.
- Writes each frame into one half of a 1024x32 ping-pong RAM.
- Hands the completed half to the downstream checker/consumer by toggling `pingpong`.
- Sits directly upstream of the packet checker that watches `pingpong` edges and reads words 11..250 of the released bank.

---
 rtl/udp_pingpong_writer_pkg.sv | 18 +
 rtl/udp_pingpong_writer_if.sv | 26 ++
 rtl/udp_pingpong_writer_sat_counter16.sv | 24 ++
 rtl/udp_pingpong_writer.sv | 151 +++++++++++++++
 tb/tb_udp_pingpong_writer.sv | 331 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/udp_pingpong_writer_pkg.sv
// Shared constants for the ping-pong frame writer and the downstream packet checker.
// State encodings, bank geometry default, frame marker and minimum length.
package udp_pingpong_writer_pkg;

    localparam int BANK_AW_DEF = 9;
    localparam int MIN_WORDS   = 251;
    localparam int MAGIC_IDX   = 11;
    localparam logic [31:0] MAGIC = 32'h3a87c5d6;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_WRITE = 2'd1;
    localparam logic [1:0] ST_DROP  = 2'd2;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/udp_pingpong_writer_if.sv
// Receive word stream in, RAM write port and bank-release flag out.
// master = stream source / RAM side, slave = the writer.
interface udp_pingpong_writer_if
    import udp_pingpong_writer_pkg::*;
#(
    parameter int BANK_AW = BANK_AW_DEF
);
    logic [31:0]      rx_data;
    logic             rx_valid;
    logic             rx_sop;
    logic             rx_eop;
    logic             ram_we;
    logic [BANK_AW:0] ram_waddr;
    logic [31:0]      ram_wdata;
    logic             pingpong;

    modport master (
        output rx_data, rx_valid, rx_sop, rx_eop,
        input  ram_we, ram_waddr, ram_wdata, pingpong
    );

    modport slave (
        input  rx_data, rx_valid, rx_sop, rx_eop,
        output ram_we, ram_waddr, ram_wdata, pingpong
    );
endinterface

// File: rtl/udp_pingpong_writer_sat_counter16.sv
// 16-bit event counter that sticks at 16'hFFFF; one increment per enabled cycle.
// Async active-high reset, no backpressure.
module sat_counter16
    import udp_pingpong_writer_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        i_inc,
    output logic [15:0] o_count
);

    logic [15:0] r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= 16'd0;
        end else if (i_inc) begin
            r_count <= sat_inc16(r_count);
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/udp_pingpong_writer.sv
// Writes UDP word frames into one half of a 2x512 ping-pong RAM (write 1 cycle after the beat, pingpong 2 cycles after eop).
// No backpressure: every valid beat is consumed. Define UDP_MAGIC_FILTER_EN to also require MAGIC at word MAGIC_IDX.
module udp_pingpong_writer
    import udp_pingpong_writer_pkg::*;
#(
    parameter int BANK_AW = BANK_AW_DEF
) (
    input  logic                 clk,
    input  logic                 RST,
    udp_pingpong_writer_if.slave bus,
    output logic [15:0]          frame_count,
    output logic [15:0]          drop_count
);

    logic [1:0]         r_state;
    logic [BANK_AW:0]   r_cnt;
    logic               r_bank;
    logic               r_commit_pend;
    logic               r_we;
    logic [BANK_AW:0]   r_waddr;
    logic [31:0]        r_wdata;
    logic               r_pingpong;

    logic [1:0]         w_state_nxt;
    logic [BANK_AW:0]   w_cnt_nxt;
    logic [BANK_AW:0]   w_len;
    logic [BANK_AW-1:0] w_idx;
    logic               w_we;
    logic               w_drop;
    logic               w_commit;
    logic               w_marker_ok;
    logic               w_bank;

    // A frame starting right behind a commit must already target the other bank.
    assign w_bank = r_commit_pend ? ~r_bank : r_bank;
    assign w_len  = r_cnt + (BANK_AW+1)'(1);

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_idx       = '0;
        w_we        = 1'b0;
        w_drop      = 1'b0;
        w_commit    = 1'b0;
        if (bus.rx_valid) begin
            if (bus.rx_sop) begin
                // Restarting over an open frame and a one-word frame both count as a single drop.
                w_we        = 1'b1;
                w_cnt_nxt   = (BANK_AW+1)'(1);
                w_drop      = bus.rx_eop || (r_state == ST_WRITE);
                w_state_nxt = bus.rx_eop ? ST_IDLE : ST_WRITE;
            end else begin
                case (r_state)
                    ST_WRITE: begin
                        if (r_cnt[BANK_AW]) begin
                            w_drop      = 1'b1;
                            w_state_nxt = bus.rx_eop ? ST_IDLE : ST_DROP;
                        end else begin
                            w_we      = 1'b1;
                            w_idx     = r_cnt[BANK_AW-1:0];
                            w_cnt_nxt = w_len;
                            if (bus.rx_eop) begin
                                w_state_nxt = ST_IDLE;
                                if ((w_len >= (BANK_AW+1)'(MIN_WORDS)) && w_marker_ok) begin
                                    w_commit = 1'b1;
                                end else begin
                                    w_drop = 1'b1;
                                end
                            end
                        end
                    end
                    ST_DROP: begin
                        if (bus.rx_eop) begin
                            w_state_nxt = ST_IDLE;
                        end
                    end
                    default: begin
                        w_state_nxt = ST_IDLE;
                    end
                endcase
            end
        end
    end

`ifdef UDP_MAGIC_FILTER_EN
    logic r_marker_ok;

    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            r_marker_ok <= 1'b0;
        end else if (w_we) begin
            if (w_idx == '0) begin
                r_marker_ok <= 1'b0;
            end else if (w_idx == BANK_AW'(MAGIC_IDX)) begin
                r_marker_ok <= (bus.rx_data == MAGIC);
            end
        end
    end

    // Any frame long enough to commit has its eop well past MAGIC_IDX, so the latch is settled.
    assign w_marker_ok = r_marker_ok;
`else
    assign w_marker_ok = 1'b1;
`endif

    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            r_state       <= ST_IDLE;
            r_cnt         <= '0;
            r_bank        <= 1'b1;
            r_commit_pend <= 1'b0;
            r_we          <= 1'b0;
            r_waddr       <= '0;
            r_wdata       <= 32'd0;
            r_pingpong    <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_cnt         <= w_cnt_nxt;
            r_commit_pend <= w_commit;
            r_we          <= w_we;
            if (w_we) begin
                r_waddr <= {w_bank, w_idx};
                r_wdata <= bus.rx_data;
            end
            if (r_commit_pend) begin
                r_bank     <= ~r_bank;
                r_pingpong <= r_bank;
            end
        end
    end

    sat_counter16 u_frame_cnt (
        .clk     (clk),
        .rst     (RST),
        .i_inc   (r_commit_pend),
        .o_count (frame_count)
    );

    sat_counter16 u_drop_cnt (
        .clk     (clk),
        .rst     (RST),
        .i_inc   (w_drop),
        .o_count (drop_count)
    );

    assign bus.ram_we    = r_we;
    assign bus.ram_waddr = r_waddr;
    assign bus.ram_wdata = r_wdata;
    assign bus.pingpong  = r_pingpong;

endmodule

// File: tb/tb_udp_pingpong_writer.sv
// Scoreboard bench for udp_pingpong_writer: expected RAM writes and pingpong edges are queued as stimulus is driven.
module tb_udp_pingpong_writer;
    import udp_pingpong_writer_pkg::*;

    logic        clk;
    logic        RST;
    logic [15:0] frame_count;
    logic [15:0] drop_count;

    udp_pingpong_writer_if #(.BANK_AW(9)) bus ();

    udp_pingpong_writer #(.BANK_AW(9)) dut (
        .clk         (clk),
        .RST         (RST),
        .bus         (bus),
        .frame_count (frame_count),
        .drop_count  (drop_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks;
    int failures;

    logic [41:0] wq[$];
    logic        pq[$];
    logic        m_bank;
    int          m_frames;
    int          m_drops;

    task automatic monitor_writes();
        logic [41:0] e;
        forever begin
            @(negedge clk);
            if (bus.ram_we === 1'b1) begin
                checks++;
                if (wq.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_write addr=%h data=%h", bus.ram_waddr, bus.ram_wdata);
                end else begin
                    e = wq.pop_front();
                    if ({bus.ram_waddr, bus.ram_wdata} !== e) begin
                        failures++;
                        $display("FAIL write addr/data got=%h/%h exp=%h/%h",
                                 bus.ram_waddr, bus.ram_wdata, e[41:32], e[31:0]);
                    end
                end
            end
        end
    endtask

    task automatic monitor_pingpong();
        logic prev;
        logic e;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            if (RST) begin
                prev = bus.pingpong;
            end else if (bus.pingpong !== prev) begin
                checks++;
                if (pq.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_pingpong_edge got=%b", bus.pingpong);
                end else begin
                    e = pq.pop_front();
                    if (bus.pingpong !== e) begin
                        failures++;
                        $display("FAIL pingpong_edge got=%b exp=%b", bus.pingpong, e);
                    end
                end
                prev = bus.pingpong;
            end
        end
    endtask

    // Drives one frame starting #1 after a posedge and queues the RAM writes it must produce.
    task automatic drive_frame(input int len, input logic [7:0] tag, input bit good_marker,
                               input bit with_eop, input int gap_every);
        logic [31:0] d;
        logic [8:0]  ia;
        for (int i = 0; i < len; i++) begin
            if (gap_every != 0 && i != 0 && (i % gap_every) == 0) begin
                bus.rx_valid = 1'b0;
                @(posedge clk);
                #1;
            end
            if (i == MAGIC_IDX) d = good_marker ? MAGIC : 32'h0;
            else                d = {tag, 24'(i)};
            bus.rx_valid = 1'b1;
            bus.rx_data  = d;
            bus.rx_sop   = (i == 0);
            bus.rx_eop   = with_eop && (i == len - 1);
            if (i < 512) begin
                ia = i[8:0];
                wq.push_back({m_bank, ia, d});
            end
            @(posedge clk);
            #1;
        end
        bus.rx_valid = 1'b0;
        bus.rx_sop   = 1'b0;
        bus.rx_eop   = 1'b0;
    endtask

    task automatic model_commit();
        pq.push_back(m_bank);
        m_bank = ~m_bank;
        m_frames++;
    endtask

    task automatic test_reset();
        RST = 1'b1;
        bus.rx_valid = 1'b0; bus.rx_sop = 1'b0; bus.rx_eop = 1'b0; bus.rx_data = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({bus.ram_we, bus.ram_waddr, bus.ram_wdata, bus.pingpong} !== 44'h0) begin
            failures++;
            $display("FAIL reset_outputs we=%b addr=%h data=%h pp=%b exp all 0",
                     bus.ram_we, bus.ram_waddr, bus.ram_wdata, bus.pingpong);
        end
        checks++;
        if (frame_count !== 16'd0 || drop_count !== 16'd0) begin
            failures++;
            $display("FAIL reset_counts frames=%0d drops=%0d exp 0/0", frame_count, drop_count);
        end
        RST = 1'b0;
        m_bank = 1'b1; m_frames = 0; m_drops = 0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_single_frame();
        drive_frame(251, 8'h00, 1'b1, 1'b1, 0);
        model_commit();
        @(negedge clk);
        checks++;
        if (bus.ram_we !== 1'b1 || bus.ram_waddr !== 10'd762 || bus.pingpong !== 1'b0) begin
            failures++;
            $display("FAIL single_last_write we=%b addr=%0d pp=%b exp 1/762/0",
                     bus.ram_we, bus.ram_waddr, bus.pingpong);
        end
        @(negedge clk);
        checks++;
        if (bus.pingpong !== 1'b1 || frame_count !== 16'd1) begin
            failures++;
            $display("FAIL single_release pp=%b frames=%0d exp 1/1", bus.pingpong, frame_count);
        end
        repeat (2) @(negedge clk);
        checks++;
        if (drop_count !== 16'd0 || wq.size() != 0) begin
            failures++;
            $display("FAIL single_drops drops=%0d pending=%0d exp 0/0", drop_count, wq.size());
        end
    endtask

    task automatic test_back_to_back();
        @(posedge clk);
        #1;
        drive_frame(251, 8'h11, 1'b1, 1'b1, 0);
        model_commit();
        drive_frame(251, 8'h12, 1'b1, 1'b1, 0);
        model_commit();
        repeat (4) @(negedge clk);
        checks++;
        if (frame_count !== 16'(m_frames) || drop_count !== 16'(m_drops)) begin
            failures++;
            $display("FAIL b2b_counts frames=%0d drops=%0d exp %0d/%0d",
                     frame_count, drop_count, m_frames, m_drops);
        end
        checks++;
        if (bus.pingpong !== 1'b1) begin
            failures++;
            $display("FAIL b2b_pingpong got=%b exp=1", bus.pingpong);
        end
    endtask

    task automatic test_short_frame();
        @(posedge clk);
        #1;
        drive_frame(100, 8'h21, 1'b1, 1'b1, 0);
        m_drops++;
        drive_frame(1, 8'h22, 1'b1, 1'b1, 0);
        m_drops++;
        drive_frame(251, 8'h23, 1'b1, 1'b1, 0);
        model_commit();
        repeat (4) @(negedge clk);
        checks++;
        if (frame_count !== 16'(m_frames) || drop_count !== 16'(m_drops)) begin
            failures++;
            $display("FAIL short_counts frames=%0d drops=%0d exp %0d/%0d",
                     frame_count, drop_count, m_frames, m_drops);
        end
    endtask

    task automatic test_overflow();
        @(posedge clk);
        #1;
        drive_frame(600, 8'h31, 1'b1, 1'b1, 0);
        m_drops++;
        repeat (3) @(negedge clk);
        checks++;
        if (drop_count !== 16'(m_drops) || wq.size() != 0) begin
            failures++;
            $display("FAIL overflow_drop drops=%0d pending=%0d exp %0d/0", drop_count, wq.size(), m_drops);
        end
        @(posedge clk);
        #1;
        drive_frame(512, 8'h32, 1'b1, 1'b1, 0);
        model_commit();
        repeat (4) @(negedge clk);
        checks++;
        if (frame_count !== 16'(m_frames) || drop_count !== 16'(m_drops)) begin
            failures++;
            $display("FAIL overflow_next frames=%0d drops=%0d exp %0d/%0d",
                     frame_count, drop_count, m_frames, m_drops);
        end
    endtask

    task automatic test_restart_and_gaps();
        @(posedge clk);
        #1;
        drive_frame(50, 8'h41, 1'b1, 1'b0, 0);
        m_drops++;
        drive_frame(251, 8'h42, 1'b1, 1'b1, 0);
        model_commit();
        drive_frame(300, 8'h43, 1'b1, 1'b1, 7);
        model_commit();
        repeat (4) @(negedge clk);
        checks++;
        if (frame_count !== 16'(m_frames) || drop_count !== 16'(m_drops)) begin
            failures++;
            $display("FAIL restart_counts frames=%0d drops=%0d exp %0d/%0d",
                     frame_count, drop_count, m_frames, m_drops);
        end
    endtask

    task automatic test_marker();
        @(posedge clk);
        #1;
        drive_frame(251, 8'h51, 1'b0, 1'b1, 0);
`ifdef UDP_MAGIC_FILTER_EN
        m_drops++;
`else
        model_commit();
`endif
        drive_frame(251, 8'h52, 1'b1, 1'b1, 0);
        model_commit();
        repeat (4) @(negedge clk);
        checks++;
        if (frame_count !== 16'(m_frames) || drop_count !== 16'(m_drops)) begin
            failures++;
            $display("FAIL marker_counts frames=%0d drops=%0d exp %0d/%0d",
                     frame_count, drop_count, m_frames, m_drops);
        end
    endtask

    task automatic test_reset_midframe();
        @(posedge clk);
        #1;
        drive_frame(30, 8'h61, 1'b1, 1'b0, 0);
        @(negedge clk);
        #1;
        RST = 1'b1;
        #1;
        checks++;
        if ({bus.ram_we, bus.ram_waddr, bus.ram_wdata, bus.pingpong} !== 44'h0) begin
            failures++;
            $display("FAIL async_reset_outputs we=%b addr=%h data=%h pp=%b exp all 0",
                     bus.ram_we, bus.ram_waddr, bus.ram_wdata, bus.pingpong);
        end
        checks++;
        if (frame_count !== 16'd0 || drop_count !== 16'd0) begin
            failures++;
            $display("FAIL async_reset_counts frames=%0d drops=%0d exp 0/0", frame_count, drop_count);
        end
        repeat (2) @(posedge clk);
        #1;
        RST = 1'b0;
        m_bank = 1'b1; m_frames = 0; m_drops = 0;
        repeat (5) @(negedge clk);
        checks++;
        if (bus.pingpong !== 1'b0 || bus.ram_we !== 1'b0) begin
            failures++;
            $display("FAIL post_reset_quiet pp=%b we=%b exp 0/0", bus.pingpong, bus.ram_we);
        end
        @(posedge clk);
        #1;
        drive_frame(251, 8'h62, 1'b1, 1'b1, 0);
        model_commit();
        repeat (4) @(negedge clk);
        checks++;
        if (bus.pingpong !== 1'b1 || frame_count !== 16'd1) begin
            failures++;
            $display("FAIL post_reset_frame pp=%b frames=%0d exp 1/1", bus.pingpong, frame_count);
        end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        m_bank = 1'b1;
        m_frames = 0;
        m_drops = 0;
        RST = 1'b1;
        bus.rx_valid = 1'b0; bus.rx_sop = 1'b0; bus.rx_eop = 1'b0; bus.rx_data = 32'h0;
        fork
            monitor_writes();
            monitor_pingpong();
        join_none
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_short_frame();
        test_overflow();
        test_restart_and_gaps();
        test_marker();
        test_reset_midframe();
        repeat (5) @(negedge clk);
        checks++;
        if (wq.size() != 0 || pq.size() != 0) begin
            failures++;
            $display("FAIL leftover_expectations writes=%0d edges=%0d exp 0/0", wq.size(), pq.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
